reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter MAX_PEND, default 3, SHALL set the maximum number of outstanding writes tracked per register (1..3).
REQ-002 Parameter ZERO_REG, default 31, SHALL name the hardwired-zero register, which is never tracked.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-low; reset==0 at a rising clk edge resets all state.
REQ-005 issue_valid  input  1  SHALL indicate that an instruction is presented for issue this cycle.
REQ-006 issue_rs1  input  5  SHALL carry the first source register number.
REQ-007 issue_rs2  input  5  SHALL carry the second source register number.
REQ-008 issue_rd  input  5  SHALL carry the destination register number.
REQ-009 issue_wr  input  1  SHALL indicate that the issuing instruction writes issue_rd.
REQ-010 wb_valid  input  1  SHALL indicate a register write retiring this cycle.
REQ-011 wb_rd  input  5  SHALL carry the retiring destination register number.
REQ-012 flush  input  1  SHALL indicate a pipeline flush.
REQ-013 stall  output  1  SHALL be the combinational hazard indication for the presented instruction.
REQ-014 busy_mask  output  32  SHALL be registered; bit n is 1 when register n has a pending count above 0.
REQ-015 pend_total  output  7  SHALL be the registered sum of all per-register pending counts.
REQ-016 wb_err  output  1  SHALL be a registered one-cycle pulse flagging an illegal retire.

Function
REQ-017 The block SHALL hold a 2-bit pending counter cnt[n] for each register n in 0..31, excluding ZERO_REG.
REQ-018 stall SHALL equal issue_valid AND (busy[rs1] OR busy[rs2] OR (issue_wr AND cnt[rd]==MAX_PEND)), where busy is the current-cycle registered state; ZERO_REG is never busy.
REQ-019 An issue SHALL be accepted when issue_valid==1, stall==0 and flush==0.
REQ-020 An accepted issue with issue_wr==1 and rd!=ZERO_REG SHALL increment cnt[rd] at the next edge.
REQ-021 wb_valid==1 with cnt[wb_rd]>0 SHALL decrement cnt[wb_rd] at the next edge.
REQ-022 wb_valid==1 with cnt[wb_rd]==0 or wb_rd==ZERO_REG SHALL leave the counters unchanged and pulse wb_err for one cycle.
REQ-023 An accepted issue and a writeback to the same register in the same cycle SHALL leave that counter unchanged; wb_err is not raised in that case even if the count is 0.
REQ-024 Counters SHALL saturate: cnt never exceeds MAX_PEND (guaranteed by the stall logic) and never wraps below 0.
REQ-025 flush==1 SHALL suppress the issue that cycle and SHALL NOT clear pending counts; in-flight writes still retire through wb.
REQ-026 busy_mask, pend_total and wb_err SHALL reflect the state after the edge, i.e. one cycle after the causing event.
REQ-027 pend_total SHALL change by +1, -1 or 0 per cycle, consistent with REQ-020 to REQ-023.

Reset
REQ-028 At a rising edge with reset==0, all cnt values, busy_mask, pend_total and wb_err SHALL become 0.
REQ-029 Reset SHALL take priority over simultaneous issue, wb and flush in the same cycle.
REQ-030 After reset, stall SHALL be 0 for any presented instruction until an issue is accepted.

Verification
REQ-031 Reset, then issue rd=5 with issue_wr=1 -> next cycle busy_mask=0x00000020 and pend_total=1; then present rs1=5 -> stall=1.
REQ-032 Issue rd=5 three times on consecutive cycles (sources unrelated), then present a fourth write to rd=5 -> stall=1 and pend_total stays 3.
REQ-033 Assert wb_valid with wb_rd=7 while cnt[7]==0 -> wb_err=1 for exactly one cycle and pend_total is unchanged.
REQ-034 With cnt[9]==1, issue rd=9 and wb rd=9 in the same cycle -> cnt[9] stays 1, busy_mask[9]=1 and pend_total is unchanged.
REQ-035 Issue rd=31, and present rs1=31 -> no busy bit is set, stall=0 and pend_total=0.
REQ-036 With pend_total=4, assert reset=0 together with issue_valid=1 for one edge -> busy_mask=0 and pend_total=0; assert flush=1 with a write issue -> no count change.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle for the register scoreboard.
// The master side presents instructions and retires, the slave side
// (the scoreboard) answers with hazard and occupancy status.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [6:0]  pend_total;
    logic        wb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        output wb_valid, wb_rd, flush,
        input  stall, busy_mask, pend_total, wb_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        input  wb_valid, wb_rd, flush,
        output stall, busy_mask, pend_total, wb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: a small saturating pending-write counter per
// architectural register. Sources or a full destination stall the
// presented instruction; retires drain the counters. The hardwired-zero
// register is never tracked, so it can never cause a hazard.
module reg_scoreboard #(
    parameter int MAX_PEND = 3,
    parameter int ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            reset,
    reg_scoreboard_if.slave bus
);

    localparam logic [4:0] ZERO = 5'(ZERO_REG);
    localparam logic [1:0] MAXC = 2'(MAX_PEND);

    logic [1:0]  cnt      [32];
    logic [1:0]  cnt_next [32];
    logic [31:0] busy_next;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rd_full;
    logic        stall_int;
    logic        accept;
    logic        inc_req;
    logic        same_reg;
    logic        do_inc;
    logic        do_dec;
    logic        wb_bad;

    // Hazard detection and the next-state counter update for this cycle.
    // An issue and a retire to the same register cancel each other out,
    // which also hides the "retire with nothing pending" error for that case.
    always_comb begin
        busy_rs1  = (cnt[bus.issue_rs1] != 2'd0);
        busy_rs2  = (cnt[bus.issue_rs2] != 2'd0);
        rd_full   = bus.issue_wr && (cnt[bus.issue_rd] == MAXC);
        stall_int = bus.issue_valid && (busy_rs1 || busy_rs2 || rd_full);
        accept    = bus.issue_valid && !stall_int && !bus.flush;
        inc_req   = accept && bus.issue_wr && (bus.issue_rd != ZERO);
        same_reg  = inc_req && bus.wb_valid && (bus.wb_rd == bus.issue_rd);
        do_inc    = inc_req && !same_reg;
        do_dec    = bus.wb_valid && !same_reg && (bus.wb_rd != ZERO)
                    && (cnt[bus.wb_rd] != 2'd0);
        wb_bad    = bus.wb_valid && !same_reg
                    && ((bus.wb_rd == ZERO) || (cnt[bus.wb_rd] == 2'd0));

        for (int n = 0; n < 32; n++) begin
            cnt_next[n] = cnt[n];
        end
        if (do_inc) begin
            cnt_next[bus.issue_rd] = cnt[bus.issue_rd] + 2'd1;
        end
        if (do_dec) begin
            cnt_next[bus.wb_rd] = cnt[bus.wb_rd] - 2'd1;
        end
        cnt_next[ZERO] = 2'd0;

        for (int n = 0; n < 32; n++) begin
            busy_next[n] = (cnt_next[n] != 2'd0);
        end
    end

    assign bus.stall = stall_int;

    // Counter state and registered status outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < 32; n++) begin
                cnt[n] <= 2'd0;
            end
            bus.busy_mask  <= 32'd0;
            bus.pend_total <= 7'd0;
            bus.wb_err     <= 1'b0;
        end else begin
            for (int n = 0; n < 32; n++) begin
                cnt[n] <= cnt_next[n];
            end
            bus.busy_mask  <= busy_next;
            bus.pend_total <= bus.pend_total + 7'(do_inc) - 7'(do_dec);
            bus.wb_err     <= wb_bad;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard. Each vector drives one
// cycle of inputs, checks the combinational stall before the edge and the
// registered status after it.
module tb_reg_scoreboard;

    logic clk;
    logic reset;

    reg_scoreboard_if bus ();

    reg_scoreboard #(
        .MAX_PEND(3),
        .ZERO_REG(31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [6:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;
    int   row;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever wanders off.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at row %0d", row);
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(
        input logic rst, input logic iv, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd, input logic wr,
        input logic wbv, input logic [4:0] wbrd, input logic fl,
        input logic e_stall, input logic [31:0] e_busy,
        input logic [6:0] e_pend, input logic e_err);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wr = wr; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
        v.e_stall = e_stall; v.e_busy = e_busy; v.e_pend = e_pend;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL row %0d %s: got 0x%08h expected 0x%08h",
                     row, name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        reset           = v.rst;
        bus.issue_valid = v.iv;
        bus.issue_rs1   = v.rs1;
        bus.issue_rs2   = v.rs2;
        bus.issue_rd    = v.rd;
        bus.issue_wr    = v.wr;
        bus.wb_valid    = v.wbv;
        bus.wb_rd       = v.wbrd;
        bus.flush       = v.fl;
        #2;
        check_output("stall", 32'(bus.stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        check_output("busy_mask", bus.busy_mask, v.e_busy);
        check_output("pend_total", 32'(bus.pend_total), 32'(v.e_pend));
        check_output("wb_err", 32'(bus.wb_err), 32'(v.e_err));
        row++;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        row             = 0;
        reset           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        bus.issue_rd    = 5'd0;
        bus.issue_wr    = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.flush       = 1'b0;

        //                rst iv  rs1 rs2 rd  wr wbv wbrd fl   stall busy          pend err
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 0,  0,  0,   0, 32'h0000_0000, 0, 0)); // reset
        vecs.push_back(mk(1, 1,  5,  6,  5,  1, 0,  0,  0,   0, 32'h0000_0020, 1, 0)); // first write rd5
        vecs.push_back(mk(1, 1,  5,  0,  1,  0, 0,  0,  0,   1, 32'h0000_0020, 1, 0)); // rs1=5 hazard
        vecs.push_back(mk(1, 1,  1,  2,  5,  1, 0,  0,  0,   0, 32'h0000_0020, 2, 0)); // rd5 #2
        vecs.push_back(mk(1, 1,  1,  2,  5,  1, 0,  0,  0,   0, 32'h0000_0020, 3, 0)); // rd5 #3
        vecs.push_back(mk(1, 1,  1,  2,  5,  1, 0,  0,  0,   1, 32'h0000_0020, 3, 0)); // rd5 full
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 1,  7,  0,   0, 32'h0000_0020, 3, 1)); // bad wb r7
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0,  0,   0, 32'h0000_0020, 3, 0)); // err one cycle
        vecs.push_back(mk(1, 1,  1,  2,  9,  1, 0,  0,  0,   0, 32'h0000_0220, 4, 0)); // cnt9=1
        vecs.push_back(mk(1, 1,  1,  2,  9,  1, 1,  9,  0,   0, 32'h0000_0220, 4, 0)); // issue+wb r9
        vecs.push_back(mk(1, 1, 31,  0, 31,  1, 0,  0,  0,   0, 32'h0000_0220, 4, 0)); // write r31 ignored
        vecs.push_back(mk(1, 1, 31, 31, 31,  1, 0,  0,  0,   0, 32'h0000_0220, 4, 0)); // r31 never busy
        vecs.push_back(mk(1, 1,  1,  2,  3,  1, 0,  0,  1,   0, 32'h0000_0220, 4, 0)); // flush suppresses
        vecs.push_back(mk(0, 1,  1,  2,  3,  1, 1,  5,  0,   0, 32'h0000_0000, 0, 0)); // reset wins
        vecs.push_back(mk(1, 1,  1,  2,  3,  1, 0,  0,  1,   0, 32'h0000_0000, 0, 0)); // flush after reset
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 1, 31,  0,   0, 32'h0000_0000, 0, 1)); // wb r31 illegal
        vecs.push_back(mk(1, 1,  1,  2,  4,  1, 1,  4,  0,   0, 32'h0000_0000, 0, 0)); // issue+wb r4 at 0
        vecs.push_back(mk(1, 1,  0,  1,  2,  1, 0,  0,  0,   0, 32'h0000_0004, 1, 0)); // write r2
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 1,  2,  0,   0, 32'h0000_0000, 0, 0)); // retire r2
        vecs.push_back(mk(1, 1,  0,  1,  2,  1, 0,  0,  0,   0, 32'h0000_0004, 1, 0)); // write r2
        vecs.push_back(mk(1, 1,  0,  2,  1,  0, 0,  0,  0,   1, 32'h0000_0004, 1, 0)); // rs2=2 hazard
        vecs.push_back(mk(1, 1,  0,  1,  6,  1, 1,  2,  0,   0, 32'h0000_0040, 1, 0)); // issue r6, wb r2
        vecs.push_back(mk(1, 0,  6,  6,  0,  0, 0,  0,  0,   0, 32'h0000_0040, 1, 0)); // no valid, no stall

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end

        // Saturate r10, then drain it fully and retire once more.
        apply_stimulus(mk(1, 1, 1, 2, 10, 1, 0,  0, 0, 0, 32'h0000_0440, 2, 0));
        apply_stimulus(mk(1, 1, 1, 2, 10, 1, 0,  0, 0, 0, 32'h0000_0440, 3, 0));
        apply_stimulus(mk(1, 1, 1, 2, 10, 1, 0,  0, 0, 0, 32'h0000_0440, 4, 0));
        apply_stimulus(mk(1, 1, 1, 2, 10, 1, 0,  0, 0, 1, 32'h0000_0440, 4, 0));
        apply_stimulus(mk(1, 0, 0, 0,  0, 0, 1, 10, 0, 0, 32'h0000_0440, 3, 0));
        apply_stimulus(mk(1, 0, 0, 0,  0, 0, 1, 10, 0, 0, 32'h0000_0440, 2, 0));
        apply_stimulus(mk(1, 0, 0, 0,  0, 0, 1, 10, 0, 0, 32'h0000_0040, 1, 0));
        apply_stimulus(mk(1, 0, 0, 0,  0, 0, 1, 10, 0, 0, 32'h0000_0040, 1, 1));
        apply_stimulus(mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0000_0040, 1, 0));

        // Reset together with issue, retire and flush all active.
        apply_stimulus(mk(0, 1, 1, 2,  6, 1, 1,  6, 1, 0, 32'h0000_0000, 0, 0));
        apply_stimulus(mk(1, 1, 6, 6,  6, 1, 0,  0, 0, 0, 32'h0000_0040, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
